// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues word reads, buffers {pc, instr} pairs for the decoder, handles redirects.
// Define FETCH_PREFETCH_EN for a two-entry prefetch buffer; otherwise a single instruction register is used.
module instr_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [15:0] redirect_pc
);

`ifdef FETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam logic [1:0] DEPTH_CNT = 2'(DEPTH);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FULL    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [1:0]  count_reg, count_next;
    logic        rd_ptr_reg, rd_ptr_next;
    logic        wr_ptr_reg, wr_ptr_next;
    logic [15:0] fetch_pc_reg, fetch_pc_next;
    logic        mem_req_reg, mem_req_next;
    logic [15:0] mem_addr_reg, mem_addr_next;
    logic        push, pop;

    logic [15:0] pc_ent   [DEPTH];
    logic [15:0] data_ent [DEPTH];

    function automatic logic ptr_adv(input logic p);
        return (DEPTH > 1) ? ~p : 1'b0;
    endfunction

    // Buffer storage: one register pair per entry, written at the write pointer on push.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [15:0] pc_reg;
        logic [15:0] data_reg;

        always_ff @(posedge clk) begin
            if (reset) begin
                pc_reg   <= 16'h0000;
                data_reg <= 16'h0000;
            end else if (push && (wr_ptr_reg == 1'(gi))) begin
                pc_reg   <= mem_addr_reg;
                data_reg <= mem_rdata;
            end
        end

        assign pc_ent[gi]   = pc_reg;
        assign data_ent[gi] = data_reg;
    end

    assign instr_valid = (count_reg != 2'd0);
    assign instr       = data_ent[rd_ptr_reg];
    assign instr_pc    = pc_ent[rd_ptr_reg];
    assign mem_req     = mem_req_reg;
    assign mem_addr    = mem_addr_reg;

    always_comb begin
        push          = 1'b0;
        pop           = 1'b0;
        state_next    = state_reg;
        count_next    = count_reg;
        rd_ptr_next   = rd_ptr_reg;
        wr_ptr_next   = wr_ptr_reg;
        fetch_pc_next = fetch_pc_reg;
        mem_req_next  = mem_req_reg;
        mem_addr_next = mem_addr_reg;

        if (redirect) begin
            count_next    = 2'd0;
            rd_ptr_next   = 1'b0;
            wr_ptr_next   = 1'b0;
            fetch_pc_next = redirect_pc;
            if (mem_req_reg && !mem_ack) begin
                // The bus read cannot be withdrawn: keep presenting it and drop its data later.
                state_next = DISCARD;
            end else begin
                state_next    = RUN;
                mem_req_next  = 1'b1;
                mem_addr_next = redirect_pc;
            end
        end else begin
            case (state_reg)
                DISCARD: begin
                    if (mem_ack) begin
                        state_next    = RUN;
                        mem_req_next  = 1'b1;
                        mem_addr_next = fetch_pc_reg;
                    end
                end
                default: begin
                    push = (state_reg == RUN) && mem_req_reg && mem_ack;
                    pop  = instr_valid && instr_ready;
                    if (push) begin
                        fetch_pc_next = fetch_pc_reg + 16'd1;
                        wr_ptr_next   = ptr_adv(wr_ptr_reg);
                    end
                    if (pop) begin
                        rd_ptr_next = ptr_adv(rd_ptr_reg);
                    end
                    count_next = count_reg + 2'(push) - 2'(pop);
                    // A new request is only launched once the previous one has completed.
                    if (!mem_req_reg || mem_ack) begin
                        mem_req_next  = (count_next < DEPTH_CNT);
                        mem_addr_next = fetch_pc_next;
                    end
                    state_next = (count_next == DEPTH_CNT) ? FULL : RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= RUN;
            count_reg    <= 2'd0;
            rd_ptr_reg   <= 1'b0;
            wr_ptr_reg   <= 1'b0;
            fetch_pc_reg <= RESET_PC;
            mem_req_reg  <= 1'b0;
            mem_addr_reg <= RESET_PC;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            rd_ptr_reg   <= rd_ptr_next;
            wr_ptr_reg   <= wr_ptr_next;
            fetch_pc_reg <= fetch_pc_next;
            mem_req_reg  <= mem_req_next;
            mem_addr_reg <= mem_addr_next;
        end
    end

endmodule
